// File: rtl/plic_claim_master.sv
// rtl/plic_claim_master.sv - APB claim/complete servicer for one PLIC context
// Optional APB wait timeout enabled by defining PLIC_CLAIM_TIMEOUT_EN.
module plic_claim_master #(
  parameter int TGT_ID    = 0,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_tgt,
  output logic        psel,
  output logic        penable,
  input  logic        pready,
  output logic [25:0] paddr,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pwstrb,
  input  logic [31:0] prdata,
  input  logic        pslverr,
  output logic        irq_valid,
  output logic [4:0]  irq_id,
  input  logic        irq_ready,
  input  logic        irq_done,
  output logic        busy,
  output logic        err
);

  localparam logic [25:0] CLAIM_ADDR = 26'h200004 + 26'(TGT_ID) * 26'h1000;

  typedef enum logic [2:0] {
    IDLE, CLM_SETUP, CLM_ACCESS, DELIVER, SERVICE, CMP_SETUP, CMP_ACCESS
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  id_q, id_d;
  logic        err_q, err_d;
  logic        psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [25:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [3:0]  pwstrb_q, pwstrb_d;
  logic        irq_valid_q, irq_valid_d, busy_q, busy_d;
  logic        in_access;
  logic        timeout;

  logic unused_prdata_hi;
  assign unused_prdata_hi = ^prdata[31:5];
  assign in_access = (state_q == CLM_ACCESS) || (state_q == CMP_ACCESS);

`ifdef PLIC_CLAIM_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  // Counter restarts at zero in the first access cycle; giving up on the
  // increment that would reach all ones bounds an access to 2^W-1 cycles.
  always_comb begin
    cnt_d = in_access ? cnt_q + 1'b1 : '0;
  end
  assign timeout = in_access && !pready && (cnt_d == {TIMEOUT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  localparam int unused_timeout_w = TIMEOUT_W;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE:       if (int_tgt) state_d = CLM_SETUP;
      CLM_SETUP:  state_d = CLM_ACCESS;
      CLM_ACCESS: begin
        if (pready) begin
          if (pslverr) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (prdata[4:0] == 5'd0) begin
            state_d = IDLE;
          end else begin
            id_d    = prdata[4:0];
            state_d = DELIVER;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DELIVER:    if (irq_ready) state_d = SERVICE;
      SERVICE:    if (irq_done) state_d = CMP_SETUP;
      CMP_SETUP:  state_d = CMP_ACCESS;
      CMP_ACCESS: begin
        if (pready) begin
          err_d   = pslverr;
          state_d = IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default:    state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered
    // in the same cycle the FSM enters each state.
    psel_d      = (state_d == CLM_SETUP) || (state_d == CLM_ACCESS) ||
                  (state_d == CMP_SETUP) || (state_d == CMP_ACCESS);
    penable_d   = (state_d == CLM_ACCESS) || (state_d == CMP_ACCESS);
    pwrite_d    = (state_d == CMP_SETUP) || (state_d == CMP_ACCESS);
    paddr_d     = psel_d ? CLAIM_ADDR : 26'h0;
    pwdata_d    = pwrite_d ? {27'b0, id_d} : 32'h0;
    pwstrb_d    = pwrite_d ? 4'hF : 4'h0;
    irq_valid_d = (state_d == DELIVER);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= 5'd0;
      err_q       <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 26'h0;
      pwdata_q    <= 32'h0;
      pwstrb_q    <= 4'h0;
      irq_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      err_q       <= err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwstrb_q    <= pwstrb_d;
      irq_valid_q <= irq_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwstrb    = pwstrb_q;
  assign irq_valid = irq_valid_q;
  assign irq_id    = id_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_plic_claim_master.sv
// tb/tb_plic_claim_master.sv - randomized self-checking bench for plic_claim_master
// Build with PLIC_CLAIM_TIMEOUT_EN defined to also exercise the APB timeout.
module tb_plic_claim_master;

  localparam logic [25:0] EXP_ADDR = 26'h201004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        int_tgt = 1'b0;
  logic        psel, penable, pwrite, irq_valid, busy, err;
  logic        pready = 1'b0, pslverr = 1'b0, irq_ready = 1'b0, irq_done = 1'b0;
  logic [25:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = 32'h0;
  logic [3:0]  pwstrb;
  logic [4:0]  irq_id;

  int checks = 0;
  int passed = 0;

  plic_claim_master #(.TGT_ID(1), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst), .int_tgt(int_tgt),
    .psel(psel), .penable(penable), .pready(pready), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb), .prdata(prdata),
    .pslverr(pslverr), .irq_valid(irq_valid), .irq_id(irq_id),
    .irq_ready(irq_ready), .irq_done(irq_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [67:0] obs();
    return {busy, err, irq_valid, psel, penable, pwrite, pwstrb, paddr, pwdata};
  endfunction

  // Expected bus from the protocol rules: phase 0 = bus idle, 1 = setup, 2 = access.
  function automatic logic [67:0] ev(bit b, bit e, bit v, int ph, bit wr, logic [4:0] id);
    bit sel = (ph != 0);
    bit w   = sel && wr;
    return {b, e, v, sel, (ph == 2), w, (w ? 4'hF : 4'h0),
            (sel ? EXP_ADDR : 26'h0), (w ? {27'b0, id} : 32'h0)};
  endfunction

  // One interrupt: claim (optionally failing or spurious), delivery, service, complete.
  task automatic run_txn(input string tag, input logic [4:0] id, input int cw, input bit cerr,
                         input int rd, input int cmpw, input bit merr);
    logic [67:0] x;
    bit deliver = !cerr && (id != 5'd0);
    int_tgt = 1'b1;
    tick();
    int_tgt = 1'b0;
    x = ev(1, 0, 0, 1, 0, id); checks++;
    if (obs() !== x) $display("FAIL %s claim_setup got %h want %h", tag, obs(), x); else passed++;
    tick();
    for (int i = 0; i <= cw; i++) begin
      x = ev(1, 0, 0, 2, 0, id); checks++;
      if (obs() !== x) $display("FAIL %s claim_access got %h want %h", tag, obs(), x); else passed++;
      if (i < cw) tick();
    end
    pready = 1'b1; pslverr = cerr; prdata = {27'($urandom), id};
    tick();
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    if (!deliver) begin
      x = ev(0, cerr, 0, 0, 0, id); checks++;
      if (obs() !== x) $display("FAIL %s claim_end got %h want %h", tag, obs(), x); else passed++;
      tick();
      x = ev(0, 0, 0, 0, 0, id); checks++;
      if (obs() !== x) $display("FAIL %s claim_idle got %h want %h", tag, obs(), x); else passed++;
      return;
    end
    for (int i = 0; i <= rd; i++) begin
      x = ev(1, 0, 1, 0, 0, id); checks++;
      if (obs() !== x || irq_id !== id)
        $display("FAIL %s deliver got %h id %0d want %h id %0d", tag, obs(), irq_id, x, id);
      else passed++;
      if (i < rd) begin
        irq_done = 1'($urandom_range(0, 1));
        tick();
        irq_done = 1'b0;
      end
    end
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
    x = ev(1, 0, 0, 0, 0, id); checks++;
    if (obs() !== x) $display("FAIL %s service got %h want %h", tag, obs(), x); else passed++;
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    x = ev(1, 0, 0, 1, 1, id); checks++;
    if (obs() !== x) $display("FAIL %s cmp_setup got %h want %h", tag, obs(), x); else passed++;
    tick();
    for (int i = 0; i <= cmpw; i++) begin
      x = ev(1, 0, 0, 2, 1, id); checks++;
      if (obs() !== x) $display("FAIL %s cmp_access got %h want %h", tag, obs(), x); else passed++;
      if (i < cmpw) tick();
    end
    pready = 1'b1; pslverr = merr;
    tick();
    pready = 1'b0; pslverr = 1'b0;
    x = ev(0, merr, 0, 0, 0, id); checks++;
    if (obs() !== x) $display("FAIL %s cmp_end got %h want %h", tag, obs(), x); else passed++;
    tick();
    x = ev(0, 0, 0, 0, 0, id); checks++;
    if (obs() !== x) $display("FAIL %s cmp_idle got %h want %h", tag, obs(), x); else passed++;
  endtask

  task automatic test_reset();
    logic [67:0] x = ev(0, 0, 0, 0, 0, 5'd0);
    rst = 1'b1; int_tgt = 1'b1;
    repeat (2) tick();
    checks++;
    if (obs() !== x || irq_id !== 5'd0)
      $display("FAIL reset got %h id %0d want %h id 0", obs(), irq_id, x);
    else passed++;
    int_tgt = 1'b0; rst = 1'b0;
    tick();
    checks++;
    if (obs() !== x) $display("FAIL reset_release got %h want %h", obs(), x); else passed++;
  endtask

  task automatic test_claim_complete();
    run_txn("basic", 5'd5, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_claim_error();
    run_txn("claim_err", 5'd9, 1, 1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_complete_wait();
    run_txn("cmp_wait", 5'd7, 0, 1'b0, 1, 3, 1'b0);
  endtask

  task automatic test_spurious_back_to_back();
    logic [67:0] x;
    int_tgt = 1'b1;
    tick();
    tick();
    pready = 1'b1; prdata = 32'hFFFF_FFE0;
    tick();
    pready = 1'b0;
    x = ev(0, 0, 0, 0, 0, 5'd0); checks++;
    if (obs() !== x) $display("FAIL spurious_idle got %h want %h", obs(), x); else passed++;
    tick();
    int_tgt = 1'b0;
    x = ev(1, 0, 0, 1, 0, 5'd0); checks++;
    if (obs() !== x) $display("FAIL back_to_back_setup got %h want %h", obs(), x); else passed++;
    tick();
    pready = 1'b1; prdata = 32'd3;
    tick();
    pready = 1'b0;
    checks++;
    if (irq_valid !== 1'b1 || irq_id !== 5'd3)
      $display("FAIL back_to_back_deliver got v%0b id %0d want v1 id 3", irq_valid, irq_id);
    else passed++;
    irq_ready = 1'b1; tick(); irq_ready = 1'b0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    tick();
    pready = 1'b1; tick(); pready = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("FAIL back_to_back_done got busy %0b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid_deliver();
    logic [67:0] x = ev(0, 0, 0, 0, 0, 5'd0);
    int_tgt = 1'b1; tick(); int_tgt = 1'b0;
    tick();
    pready = 1'b1; prdata = 32'd17; tick(); pready = 1'b0;
    checks++;
    if (irq_valid !== 1'b1) $display("FAIL pre_reset_deliver got %0b want 1", irq_valid); else passed++;
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (obs() !== x || irq_id !== 5'd0)
      $display("FAIL reset_mid_deliver got %h id %0d want %h id 0", obs(), irq_id, x);
    else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      run_txn($sformatf("rand%0d", n), 5'($urandom_range(0, 31)), $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

`ifdef PLIC_CLAIM_TIMEOUT_EN
  task automatic test_timeout();
    logic [67:0] x;
    int_tgt = 1'b1; tick(); int_tgt = 1'b0;
    tick();
    repeat (14) tick();
    x = ev(1, 0, 0, 2, 0, 5'd0); checks++;
    if (obs() !== x) $display("FAIL timeout_access15 got %h want %h", obs(), x); else passed++;
    tick();
    x = ev(0, 1, 0, 0, 0, 5'd0); checks++;
    if (obs() !== x) $display("FAIL timeout_err got %h want %h", obs(), x); else passed++;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_claim_complete();
    test_claim_error();
    test_spurious_back_to_back();
    test_complete_wait();
`ifdef PLIC_CLAIM_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    test_reset_mid_deliver();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
